// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch/jump redirect, data-memory
// access over a req/ready handshake with timeout, and the MEM/WB register.
module mem_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_write_reg,
    input  logic [31:0] in_write_data,
    input  logic [31:0] in_alu_result,
    input  logic        in_zero,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc_jump,
    input  logic [27:0] in_jump_inst,
    input  logic        in_branch,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_reg_write,
    input  logic        in_mem_reg,
    input  logic        in_jump,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic [4:0]  out_write_reg,
    output logic [31:0] out_read_data,
    output logic [31:0] out_alu_result,
    output logic        out_reg_write,
    output logic        out_mem_reg,
    output logic        mem_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       access;
    logic       load_done;

    assign access       = in_mem_read | in_mem_write;
    assign dmem_req     = access && (state != S_ABORT);
    assign dmem_we      = in_mem_write;
    assign dmem_addr    = in_alu_result;
    assign dmem_wdata   = in_write_data;
    assign stall        = dmem_req && !dmem_ready;
    // A read-and-write instruction is treated as a store, so it never returns data.
    assign load_done    = dmem_req && dmem_ready && !in_mem_write;
    assign wait_cnt_inc = wait_cnt + 8'd1;

    assign pc_src    = ((in_branch & in_zero) | in_jump) & ~stall;
    assign pc_target = in_jump ? {in_pc[31:28], in_jump_inst} : in_pc_jump;

    // The abort threshold counts stalled cycles, so an access stalls at most
    // MAX_WAIT cycles before the single ABORT cycle releases the pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && !dmem_ready) begin
                        wait_cnt <= 8'd1;
                        if (MAX_WAIT_L <= 8'd1) begin
                            state   <= S_ABORT;
                            mem_err <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        state    <= S_IDLE;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc >= MAX_WAIT_L) begin
                            state   <= S_ABORT;
                            mem_err <= 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    state    <= S_IDLE;
                    wait_cnt <= 8'd0;
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register: a stall inserts a bubble, an aborted access is squashed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_write_reg  <= 5'd0;
            out_read_data  <= 32'd0;
            out_alu_result <= 32'd0;
            out_reg_write  <= 1'b0;
            out_mem_reg    <= 1'b0;
        end else if (stall) begin
            out_reg_write <= 1'b0;
            out_mem_reg   <= 1'b0;
        end else begin
            out_write_reg  <= in_write_reg;
            out_alu_result <= in_alu_result;
            out_mem_reg    <= in_mem_reg;
            out_reg_write  <= in_reg_write && (state != S_ABORT);
            out_read_data  <= load_done ? dmem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// traffic compared every cycle against a behavioural access model.
module tb_mem_stage;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_write_reg;
    logic [31:0] in_write_data;
    logic [31:0] in_alu_result;
    logic        in_zero;
    logic [31:0] in_pc;
    logic [31:0] in_pc_jump;
    logic [27:0] in_jump_inst;
    logic        in_branch;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_reg_write;
    logic        in_mem_reg;
    logic        in_jump;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [4:0]  out_write_reg;
    logic [31:0] out_read_data;
    logic [31:0] out_alu_result;
    logic        out_reg_write;
    logic        out_mem_reg;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .in_write_reg(in_write_reg), .in_write_data(in_write_data),
        .in_alu_result(in_alu_result), .in_zero(in_zero), .in_pc(in_pc),
        .in_pc_jump(in_pc_jump), .in_jump_inst(in_jump_inst),
        .in_branch(in_branch), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
        .in_mem_reg(in_mem_reg), .in_jump(in_jump),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src),
        .pc_target(pc_target), .out_write_reg(out_write_reg),
        .out_read_data(out_read_data), .out_alu_result(out_alu_result),
        .out_reg_write(out_reg_write), .out_mem_reg(out_mem_reg),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: how many cycles the current access has waited,
    // whether it is in its abort cycle, and the expected writeback record.
    bit          model_valid = 0;
    int          waited = 0;
    bit          aborting = 0;
    bit          exp_err = 0;
    logic [4:0]  exp_wreg = '0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_alu = '0;
    bit          exp_rw = 0;
    bit          exp_mr = 0;

    always @(posedge clk) begin
        bit acc;
        bit stl;
        acc = in_mem_read || in_mem_write;
        stl = acc && !aborting && !dmem_ready;
        if (!rst) begin
            model_valid = 1;
            waited = 0; aborting = 0; exp_err = 0;
            exp_wreg = '0; exp_rdata = '0; exp_alu = '0; exp_rw = 0; exp_mr = 0;
        end else begin
            if (stl) begin
                exp_rw = 0;
                exp_mr = 0;
            end else begin
                exp_wreg  = in_write_reg;
                exp_alu   = in_alu_result;
                exp_mr    = in_mem_reg;
                exp_rw    = in_reg_write && !aborting;
                exp_rdata = (acc && !aborting && dmem_ready && !in_mem_write) ? dmem_rdata : 32'd0;
            end
            if (aborting) begin
                aborting = 0;
                waited = 0;
            end else if (acc) begin
                if (dmem_ready) waited = 0;
                else begin
                    waited++;
                    if (waited >= MAX_WAIT) begin
                        aborting = 1;
                        exp_err = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            bit acc;
            bit exp_req;
            bit exp_stall;
            logic [31:0] exp_tgt;
            acc       = in_mem_read || in_mem_write;
            exp_req   = acc && !aborting;
            exp_stall = exp_req && !dmem_ready;
            exp_tgt   = in_jump ? ((in_pc & 32'hF000_0000) | {4'd0, in_jump_inst}) : in_pc_jump;
            checkOutput("dmem_req", dmem_req, exp_req);
            checkOutput("dmem_we", dmem_we, in_mem_write);
            checkOutput("dmem_addr", dmem_addr, in_alu_result);
            checkOutput("dmem_wdata", dmem_wdata, in_write_data);
            checkOutput("stall", stall, exp_stall);
            checkOutput("pc_src", pc_src, ((in_branch && in_zero) || in_jump) && !exp_stall);
            checkOutput("pc_target", pc_target, exp_tgt);
            checkOutput("out_write_reg", out_write_reg, exp_wreg);
            checkOutput("out_read_data", out_read_data, exp_rdata);
            checkOutput("out_alu_result", out_alu_result, exp_alu);
            checkOutput("out_reg_write", out_reg_write, exp_rw);
            checkOutput("out_mem_reg", out_mem_reg, exp_mr);
            checkOutput("mem_err", mem_err, exp_err);
        end
    end

    task automatic clearInputs();
        in_write_reg = '0; in_write_data = '0; in_alu_result = '0; in_zero = 0;
        in_pc = '0; in_pc_jump = '0; in_jump_inst = '0; in_branch = 0;
        in_mem_read = 0; in_mem_write = 0; in_reg_write = 0; in_mem_reg = 0;
        in_jump = 0; dmem_ready = 0; dmem_rdata = '0;
    endtask

    task automatic applyStimulus();
        int op;
        op = $urandom_range(0, 3);
        in_write_reg  = 5'($urandom);
        in_write_data = $urandom;
        in_alu_result = $urandom;
        in_zero       = 1'($urandom);
        in_pc         = $urandom;
        in_pc_jump    = $urandom;
        in_jump_inst  = 28'($urandom);
        in_branch     = (op == 3) && 1'($urandom);
        in_jump       = (op == 3) && 1'($urandom);
        in_mem_read   = (op == 1) || ((op == 2) && ($urandom_range(0, 7) == 0));
        in_mem_write  = (op == 2);
        in_reg_write  = (op == 0) || (op == 1);
        in_mem_reg    = (op == 1);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit held;
        rst = 0;
        applyStimulus();
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        nextCycle();
        nextCycle();
        checkOutput("rst_out_reg_write", out_reg_write, 0);
        checkOutput("rst_out_alu_result", out_alu_result, 0);
        checkOutput("rst_mem_err", mem_err, 0);

        rst = 1;
        clearInputs();
        in_mem_read = 1;
        #1 checkOutput("req_after_rst", dmem_req, 1);

        clearInputs();
        in_reg_write = 1; in_write_reg = 5; in_alu_result = 32'h1234;
        #1 checkOutput("alu_no_stall", stall, 0);
        nextCycle();
        checkOutput("alu_wreg", out_write_reg, 5);
        checkOutput("alu_result", out_alu_result, 32'h1234);
        checkOutput("alu_rw", out_reg_write, 1);

        clearInputs();
        in_mem_read = 1; in_mem_reg = 1; in_reg_write = 1; in_write_reg = 7;
        in_alu_result = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("load_stall", stall, 1);
            nextCycle();
            checkOutput("load_bubble", out_reg_write, 0);
        end
        dmem_ready = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1 checkOutput("load_done_stall", stall, 0);
        nextCycle();
        checkOutput("load_rdata", out_read_data, 32'hDEAD_BEEF);
        checkOutput("load_rw", out_reg_write, 1);
        checkOutput("load_mr", out_mem_reg, 1);

        clearInputs();
        in_mem_write = 1; in_write_data = 32'hCAFE_F00D; dmem_ready = 1;
        #1;
        checkOutput("store_req", dmem_req, 1);
        checkOutput("store_we", dmem_we, 1);
        checkOutput("store_stall", stall, 0);
        nextCycle();
        checkOutput("store_rdata", out_read_data, 0);

        clearInputs();
        in_branch = 1; in_zero = 1; in_pc_jump = 32'h100;
        #1;
        checkOutput("br_src", pc_src, 1);
        checkOutput("br_target", pc_target, 32'h100);
        in_jump = 1; in_pc = 32'h8000_0004; in_jump_inst = 28'h000_0200;
        #1 checkOutput("jmp_target", pc_target, 32'h8000_0200);
        nextCycle();
        clearInputs();
        in_branch = 1; in_zero = 1; in_pc_jump = 32'h200; in_mem_read = 1;
        for (int i = 0; i < 2; i++) begin
            #1 checkOutput("br_stalled_src", pc_src, 0);
            nextCycle();
        end
        dmem_ready = 1;
        #1 checkOutput("br_final_src", pc_src, 1);
        nextCycle();

        clearInputs();
        in_mem_read = 1; in_reg_write = 1; in_write_reg = 9;
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1 checkOutput("to_stall", stall, 1);
            nextCycle();
        end
        #1;
        checkOutput("abort_stall", stall, 0);
        checkOutput("abort_req", dmem_req, 0);
        checkOutput("abort_err", mem_err, 1);
        nextCycle();
        checkOutput("abort_rw", out_reg_write, 0);
        checkOutput("abort_rdata", out_read_data, 0);
        clearInputs();
        nextCycle();
        nextCycle();
        checkOutput("err_sticky", mem_err, 1);

        in_mem_read = 1;
        nextCycle();
        rst = 0;
        clearInputs();
        #1 checkOutput("rst_req_drop", dmem_req, 0);
        nextCycle();
        rst = 1;
        checkOutput("rst_err_clear", mem_err, 0);
        in_mem_read = 1; dmem_ready = 1;
        #1 checkOutput("post_rst_no_stall", stall, 0);
        nextCycle();

        // Randomized traffic: an instruction is held while the stage stalls.
        held = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!held) applyStimulus();
            dmem_ready = ($urandom_range(0, 9) < 4);
            dmem_rdata = $urandom;
            rst = ($urandom_range(0, 79) != 0);
            @(negedge clk);
            held = stall;
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
